// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: holds the PC, waits out the instruction ROM
// latency, presents {pc, inst} to ID and selects the next PC (exception, jump/branch, pc+4).
module fetch_stage #(
   parameter logic [31:0] STARTADDR = 32'h0000_0000,
   parameter int          ROM_LAT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        IF_valid,
   input  logic        next_fetch,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst,
   input  logic [32:0] jbr_bus,
   input  logic [32:0] exc_bus,
   output logic        IF_over,
   output logic [63:0] IF_ID_bus,
   output logic [31:0] IF_pc,
   output logic [31:0] IF_inst
);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_DONE  = 1'b1
   } state_t;

   localparam logic [2:0] LAST_CNT = 3'(ROM_LAT - 1);

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic        r_pend_exc;
   logic [31:0] r_pend_pc;

   logic        w_adv;
   logic [31:0] w_next_pc;

   // Advance only when the captured instruction is handed to ID.
   assign w_adv = IF_valid & (r_state == S_DONE) & next_fetch;

   // Next-PC select: live exception beats a latched one, which beats a taken jbr.
   always_comb begin
      w_next_pc = r_pc + 32'd4;
      if (exc_bus[32]) begin
         w_next_pc = exc_bus[31:0];
      end else if (r_pend_exc) begin
         w_next_pc = r_pend_pc;
      end else if (jbr_bus[32]) begin
         w_next_pc = jbr_bus[31:0];
      end else begin
         w_next_pc = r_pc + 32'd4;
      end
   end

   // Exception latch: an exception pulse arriving before next_fetch is held until consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend_exc <= 1'b0;
         r_pend_pc  <= 32'h0000_0000;
      end else if (w_adv) begin
         r_pend_exc <= 1'b0;
      end else if (exc_bus[32]) begin
         r_pend_exc <= 1'b1;
         r_pend_pc  <= exc_bus[31:0];
      end else begin
         r_pend_exc <= r_pend_exc;
      end
   end

   // Fetch FSM: count out the ROM latency, capture, then hold until ID takes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_cnt   <= 3'd0;
         r_pc    <= STARTADDR;
         r_inst  <= 32'h0000_0000;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (IF_valid) begin
                  r_cnt <= r_cnt + 3'd1;
                  if (r_cnt == LAST_CNT) begin
                     r_inst  <= inst;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (w_adv) begin
                  r_pc    <= w_next_pc;
                  r_cnt   <= 3'd0;
                  r_state <= S_FETCH;
               end
            end
            default: begin
               r_state <= S_FETCH;
               r_cnt   <= 3'd0;
            end
         endcase
      end
   end

   assign inst_addr = r_pc;
   assign IF_over   = IF_valid & (r_state == S_DONE);
   assign IF_ID_bus = {r_pc, r_inst};
   assign IF_pc     = r_pc;
   assign IF_inst   = r_inst;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one ROM_LAT=1 instance for the main flow and one
// ROM_LAT=3 instance for the latency/stall case.
module tb_fetch_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // ROM_LAT = 1 instance
   logic        reset, if_valid, next_fetch;
   logic [32:0] jbr_bus, exc_bus;
   logic [31:0] inst_addr, inst, IF_pc, IF_inst;
   logic        IF_over;
   logic [63:0] IF_ID_bus;
   assign inst = rom(inst_addr);

   fetch_stage #(.STARTADDR(32'h0000_0000), .ROM_LAT(1)) u_dut (
      .clk(clk), .reset(reset), .IF_valid(if_valid), .next_fetch(next_fetch),
      .inst_addr(inst_addr), .inst(inst), .jbr_bus(jbr_bus), .exc_bus(exc_bus),
      .IF_over(IF_over), .IF_ID_bus(IF_ID_bus), .IF_pc(IF_pc), .IF_inst(IF_inst)
   );

   // ROM_LAT = 3 instance
   logic        reset3, if_valid3, next_fetch3;
   logic [32:0] jbr_bus3, exc_bus3;
   logic [31:0] inst_addr3, inst3, IF_pc3, IF_inst3;
   logic        IF_over3;
   logic [63:0] IF_ID_bus3;
   assign inst3 = rom(inst_addr3);

   fetch_stage #(.STARTADDR(32'h0000_0000), .ROM_LAT(3)) u_dut3 (
      .clk(clk), .reset(reset3), .IF_valid(if_valid3), .next_fetch(next_fetch3),
      .inst_addr(inst_addr3), .inst(inst3), .jbr_bus(jbr_bus3), .exc_bus(exc_bus3),
      .IF_over(IF_over3), .IF_ID_bus(IF_ID_bus3), .IF_pc(IF_pc3), .IF_inst(IF_inst3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hand the current instruction to ID, then wait one fetch (ROM_LAT=1).
   task automatic advance(input logic [31:0] exp_pc);
      next_fetch = 1'b1;
      tick();
      next_fetch = 1'b0;
      jbr_bus    = 33'd0;
      exc_bus    = 33'd0;
      chk("adv_pc", {32'd0, IF_pc}, {32'd0, exp_pc});
      chk("adv_over_low", {63'd0, IF_over}, 64'd0);
      tick();
      chk("adv_over_high", {63'd0, IF_over}, 64'd1);
      chk("adv_bus", IF_ID_bus, {exp_pc, rom(exp_pc)});
   endtask

   initial begin
      reset = 1'b1; if_valid = 1'b1; next_fetch = 1'b0; jbr_bus = 33'd0; exc_bus = 33'd0;
      reset3 = 1'b1; if_valid3 = 1'b1; next_fetch3 = 1'b0; jbr_bus3 = 33'd0; exc_bus3 = 33'd0;
      #12;
      // Reset state
      chk("rst_addr", {32'd0, inst_addr}, 64'd0);
      chk("rst_over", {63'd0, IF_over}, 64'd0);
      chk("rst_bus", IF_ID_bus, 64'd0);
      reset = 1'b0;
      tick();
      chk("first_over", {63'd0, IF_over}, 64'd1);
      chk("first_bus", IF_ID_bus, {32'h0, rom(32'h0)});
      chk("first_inst", {32'd0, IF_inst}, {32'd0, rom(32'h0)});

      // Sequential fetch
      advance(32'h4);
      advance(32'h8);

      // Taken jbr at pc=8
      jbr_bus = {1'b1, 32'h0000_0100};
      advance(32'h100);

      // Jump to C, exception pulse during its fetch, then jbr loses to the pending exception
      jbr_bus = {1'b1, 32'h0000_000C};
      next_fetch = 1'b1;
      tick();
      next_fetch = 1'b0;
      jbr_bus = 33'd0;
      chk("pc_c", {32'd0, IF_pc}, 64'hC);
      exc_bus = {1'b1, 32'h0000_0380};
      tick();
      exc_bus = 33'd0;
      chk("c_over", {63'd0, IF_over}, 64'd1);
      jbr_bus = {1'b1, 32'h0000_0200};
      advance(32'h380);
      advance(32'h384);

      // Live exception together with next_fetch beats jbr; nothing left pending
      exc_bus = {1'b1, 32'h0000_0500};
      jbr_bus = {1'b1, 32'h0000_0200};
      advance(32'h500);
      advance(32'h504);

      // Two exceptions before consumption: newest wins
      next_fetch = 1'b1;
      tick();
      next_fetch = 1'b0;
      exc_bus = {1'b1, 32'h0000_0600};
      tick();
      exc_bus = {1'b1, 32'h0000_0700};
      tick();
      exc_bus = 33'd0;
      advance(32'h700);

      // IF_valid low freezes everything and masks IF_over
      if_valid = 1'b0;
      #1;
      chk("inv_over", {63'd0, IF_over}, 64'd0);
      next_fetch = 1'b1;
      tick();
      next_fetch = 1'b0;
      chk("inv_pc_hold", {32'd0, IF_pc}, 64'h700);
      if_valid = 1'b1;
      #1;
      chk("inv_over_back", {63'd0, IF_over}, 64'd1);

      // PC wrap
      exc_bus = {1'b1, 32'hFFFF_FFFC};
      advance(32'hFFFF_FFFC);
      advance(32'h0);

      // Async reset in the middle of a fetch
      jbr_bus = {1'b1, 32'h0000_0040};
      next_fetch = 1'b1;
      tick();
      next_fetch = 1'b0;
      jbr_bus = 33'd0;
      chk("pc_40", {32'd0, IF_pc}, 64'h40);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_pc", {32'd0, IF_pc}, 64'd0);
      chk("arst_over", {63'd0, IF_over}, 64'd0);
      chk("arst_bus", IF_ID_bus, 64'd0);
      reset = 1'b0;
      tick();
      chk("arst_refetch", {63'd0, IF_over}, 64'd1);

      // ROM_LAT=3: plain latency after reset release
      reset3 = 1'b0;
      tick();
      chk("l3_e1", {63'd0, IF_over3}, 64'd0);
      tick();
      chk("l3_e2", {63'd0, IF_over3}, 64'd0);
      tick();
      chk("l3_e3", {63'd0, IF_over3}, 64'd1);
      chk("l3_bus0", IF_ID_bus3, {32'h0, rom(32'h0)});

      // ROM_LAT=3 with a two-cycle IF_valid stall mid-fetch
      next_fetch3 = 1'b1;
      tick();
      next_fetch3 = 1'b0;
      chk("l3_pc4", {32'd0, IF_pc3}, 64'h4);
      tick();
      if_valid3 = 1'b0;
      tick();
      tick();
      if_valid3 = 1'b1;
      tick();
      chk("l3_stall_e4", {63'd0, IF_over3}, 64'd0);
      tick();
      chk("l3_stall_e5", {63'd0, IF_over3}, 64'd1);
      chk("l3_inst4", {32'd0, IF_inst3}, {32'd0, rom(32'h4)});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
